root_5_seq: RTL and testbench
=============================

# root_5_seq

Sequential integer fifth-root unit, the inverse of the `pow_5` pipeline family. It accepts a `5*W`-bit operand through a valid/ready handshake and returns `floor(x^(1/5))` after a fixed number of enabled cycles. It uses one shared multiplier and works one root bit per iteration, from MSB to LSB. It sits on the board-independent wrapper, fed by switches and keys, with its result driven to the display.

## Interface
- `W`, 8, root width in bits; operand width is `5*W`.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  clock enable; no state changes when low.
- `x_vld`  in  1  operand valid.
- `x`  in  `5*W`  operand, unsigned.
- `x_rdy`  out  1  ready to accept an operand; high only in IDLE.
- `res_vld`  out  1  result valid, high for exactly one enabled cycle.
- `res`  out  `W`  root, unsigned; held until the next result.
- `res_exact`  out  1  `res^5 == x`; present only with `ROOT_5_EXACT_EN`.

## Operation
- FSM states: IDLE, LOAD, MUL, CMP, DONE. All transitions occur on `clk` edges with `clk_en` = 1.
- **IDLE:** `x_rdy` = 1. When `x_vld` is high:
  - latch `x` into `x_q`
  - clear `root` to 0
  - set bit index `i` = `W-1`
  - go to LOAD.
- **LOAD:** set `cand = root | (1 << i)` and `p = cand`; set multiply count `k` = 0; go to MUL.
- **MUL:** `p = p * cand`, truncated to `5*W` bits. Truncation is lossless because `cand^5 < 2^(5W)`. Increment `k`; after 4 multiplies go to CMP.
- **CMP:**
  - If `p <= x_q`, set `root = cand`.
  - If `i` = 0, go to DONE; otherwise decrement `i` and go to LOAD.
- **DONE:** `res_vld` = 1, `res` = `root`; next enabled cycle goes to IDLE.
- `x_vld` is ignored outside IDLE; an operand is never queued.
- `res` updates only on entry to DONE and holds its value between results.
- Comparisons are unsigned, full `5*W` bits.

## Timing
- Reset values:
  - state = IDLE
  - `x_rdy` = 1
  - `res_vld` = 0
  - `res` = 0
  - `res_exact` = 0
  - all internal registers = 0.
- An operand is accepted on enabled edge E0 where `x_vld & x_rdy` is high.
- Each root bit takes 6 enabled cycles (LOAD, 4×MUL, CMP).
- DONE is entered on enabled edge E0+6W; `res_vld` is high from then until the next enabled edge. For W=8 this is edge 48.
- `x_rdy` drops immediately after E0 and returns one enabled cycle after DONE. Throughput is one operand per `6W+2` enabled cycles.
- While `clk_en` = 0, all outputs hold. `res_vld` can therefore stay high across disabled cycles but covers exactly one enabled cycle.
- Reset asserted mid-operation: the FSM returns to IDLE immediately, outputs take their reset values, and the partial result is discarded.
- Boundary cases:
  - `x` = 0 gives `res` = 0.
  - `x` = `2^(5W)-1` gives `res` = `2^W-1`.
  - No overflow or wrap is possible.

## Configuration
- `ROOT_5_EXACT_EN` defined:
  - Adds the `res_exact` port and a `5*W`-bit register `root_pow`.
  - `root_pow` loads `p` in CMP whenever the candidate bit is accepted.
  - On entry to DONE, `res_exact = (root_pow == x_q)`, held alongside `res`.
  - When `x` = 0 no candidate is accepted; `root_pow` stays 0, so `res_exact` = 1.
- Not defined: no `res_exact` port and no `root_pow` register; all other behaviour is identical.

## Test plan
- Reset, then W=8, `x` = 100000 with `clk_en` held at 1: `res_vld` is high exactly 48 cycles after acceptance, `res` = 10, `res_exact` = 1.
- `x` = 242 gives `res` = 2, `res_exact` = 0; `x` = 243 gives `res` = 3, `res_exact` = 1; `x` = 0 gives `res` = 0, `res_exact` = 1.
- `x` = `2^40-1` gives `res` = 255, `res_exact` = 0; `x` = 1078203909375 (255^5) gives `res` = 255, `res_exact` = 1.
- `clk_en` toggling 1-0-0 repeatedly with `x` = 32:
  - `res` = 2 after 48 enabled edges.
  - `res_vld` spans exactly one enabled cycle.
  - A new `x` driven while busy is ignored; `x_rdy` = 0 throughout.
- `rst_n` pulsed low at cycle 20 of an operation: all outputs return to reset values immediately. A following `x` = 3125 yields `res` = 5 with normal latency.
- Back-to-back operands with `x_vld` held high: the second operand is accepted exactly 50 enabled cycles after the first, and each `res_vld` pulse carries the correct root.

Source files
------------

// File: rtl/root_5_seq.sv
// root_5_seq: sequential floor(x^(1/5)), one root bit per 6 enabled cycles on a shared multiplier.
// Optional feature: define ROOT_5_EXACT_EN to add res_exact (res^5 == x).
module root_5_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  input  logic           x_vld,
  input  logic [5*W-1:0] x,
  output logic           x_rdy,
  output logic           res_vld,
`ifdef ROOT_5_EXACT_EN
  output logic           res_exact,
`endif
  output logic [W-1:0]   res
);
  localparam int XW = 5 * W;
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, MUL, CMP, DONE} state_t;
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d, p_q, p_d;
  logic [W-1:0] root_q, root_d, cand_q, cand_d, res_q, res_d;
  logic [IW-1:0] i_q, i_d;
  logic [1:0] k_q, k_d;
  logic hit;
`ifdef ROOT_5_EXACT_EN
  logic [XW-1:0] root_pow_q, root_pow_d;
  logic res_exact_q, res_exact_d;
`endif
  assign hit = p_q <= x_q;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    p_d = p_q;
    root_d = root_q;
    cand_d = cand_q;
    res_d = res_q;
    i_d = i_q;
    k_d = k_q;
`ifdef ROOT_5_EXACT_EN
    root_pow_d = root_pow_q;
    res_exact_d = res_exact_q;
`endif
    case (state_q)
      IDLE: if (x_vld) begin
        x_d = x;
        root_d = '0;
        i_d = IW'(W - 1);
`ifdef ROOT_5_EXACT_EN
        root_pow_d = '0;
`endif
        state_d = LOAD;
      end
      LOAD: begin
        cand_d = root_q | (W'(1) << i_q);
        p_d = XW'(cand_d);
        k_d = 2'd0;
        state_d = MUL;
      end
      MUL: begin
        // cand^5 fits in XW bits, so the truncated product is exact
        p_d = p_q * XW'(cand_q);
        k_d = k_q + 2'd1;
        state_d = (k_q == 2'd3) ? CMP : MUL;
      end
      CMP: begin
        root_d = hit ? cand_q : root_q;
`ifdef ROOT_5_EXACT_EN
        root_pow_d = hit ? p_q : root_pow_q;
`endif
        if (i_q == '0) begin
          res_d = root_d;
`ifdef ROOT_5_EXACT_EN
          res_exact_d = root_pow_d == x_q;
`endif
          state_d = DONE;
        end else begin
          i_d = i_q - IW'(1);
          state_d = LOAD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      p_q <= '0;
      root_q <= '0;
      cand_q <= '0;
      res_q <= '0;
      i_q <= '0;
      k_q <= '0;
`ifdef ROOT_5_EXACT_EN
      root_pow_q <= '0;
      res_exact_q <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q <= state_d;
      x_q <= x_d;
      p_q <= p_d;
      root_q <= root_d;
      cand_q <= cand_d;
      res_q <= res_d;
      i_q <= i_d;
      k_q <= k_d;
`ifdef ROOT_5_EXACT_EN
      root_pow_q <= root_pow_d;
      res_exact_q <= res_exact_d;
`endif
    end
  end
  assign x_rdy = state_q == IDLE;
  assign res_vld = state_q == DONE;
  assign res = res_q;
`ifdef ROOT_5_EXACT_EN
  assign res_exact = res_exact_q;
`endif
endmodule

// File: tb/tb_root_5_seq.sv
// tb_root_5_seq: randomized and directed checks of root_5_seq against a brute-force fifth-root model.
module tb_root_5_seq;
  localparam int W = 8;
  localparam int XW = 5 * W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;
  logic x_vld = 1'b0;
  logic [XW-1:0] x = '0;
  logic x_rdy, res_vld;
  logic [W-1:0] res;
`ifdef ROOT_5_EXACT_EN
  logic res_exact;
`endif
  int n_chk = 0;
  int n_err = 0;

  root_5_seq #(.W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_en(clk_en),
    .x_vld(x_vld),
    .x(x),
    .x_rdy(x_rdy),
    .res_vld(res_vld),
`ifdef ROOT_5_EXACT_EN
    .res_exact(res_exact),
`endif
    .res(res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned pow5(input longint unsigned c);
    return c * c * c * c * c;
  endfunction

  function automatic int ref_root(input logic [XW-1:0] v);
    int r = 0;
    for (int c = 1; c < (1 << W); c++)
      if (pow5(longint'(c)) <= 64'(v)) r = c;
    return r;
  endfunction

  // One operation; tog gives a 1-0-0 clk_en pattern and drives junk operands while busy.
  task automatic run_op(input string tag, input logic [XW-1:0] xv, input bit tog);
    int cyc = 0;
    int en = 0;
    int lat = -1;
    int r;
    bit acc = 0;
    bit fin = 0;
    bit busy_bad = 0;
    bit hold_bad = 0;
    bit rdy_pre;
    r = ref_root(xv);
    x = xv;
    x_vld = 1'b1;
    while (!fin && cyc < 4000) begin
      clk_en = tog ? (cyc % 3 == 0) : 1'b1;
      rdy_pre = x_rdy;
      @(posedge clk);
      #1;
      cyc++;
      if (!acc) begin
        if (clk_en && rdy_pre) begin
          acc = 1;
          x = XW'({$urandom, $urandom});
          x_vld = tog;
        end
      end else if (lat < 0) begin
        if (clk_en) en++;
        if (x_rdy) busy_bad = 1;
        if (clk_en && res_vld) begin
          lat = en;
          x_vld = 1'b0;
          check({tag, " res"}, 64'(res), 64'(r));
`ifdef ROOT_5_EXACT_EN
          check({tag, " exact"}, 64'(res_exact), 64'(pow5(longint'(r)) == 64'(xv)));
`endif
        end
      end else if (!clk_en) begin
        if (!res_vld) hold_bad = 1;
      end else fin = 1;
    end
    check({tag, " latency"}, 64'(lat), 64'(6 * W));
    check({tag, " x_rdy low while busy"}, 64'(busy_bad), 64'd0);
    check({tag, " res_vld held while disabled"}, 64'(hold_bad), 64'd0);
    check({tag, " res_vld one enabled cycle"}, 64'(res_vld), 64'd0);
    check({tag, " x_rdy back"}, 64'(x_rdy), 64'd1);
    check({tag, " res held"}, 64'(res), 64'(r));
  endtask

  initial begin
    logic [XW-1:0] xr;
    bit pre;
    int acc2;
    int vld_cnt;
    int ra, rb;
    #12;
    check("reset x_rdy", 64'(x_rdy), 64'd1);
    check("reset res_vld", 64'(res_vld), 64'd0);
    check("reset res", 64'(res), 64'd0);
`ifdef ROOT_5_EXACT_EN
    check("reset res_exact", 64'(res_exact), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);

    run_op("x100000", XW'(100000), 0);
    run_op("x242", XW'(242), 0);
    run_op("x243", XW'(243), 0);
    run_op("x0", XW'(0), 0);
    run_op("xmax", {XW{1'b1}}, 0);
    run_op("x255p5", XW'(64'd1078203909375), 0);
    run_op("x32 toggled", XW'(32), 1);
    for (int n = 0; n < 12; n++) begin
      case (n % 3)
        0: xr = XW'({$urandom, $urandom});
        1: xr = XW'(pow5(longint'($urandom_range(0, 255))));
        default: xr = XW'(pow5(longint'($urandom_range(1, 255))) - 64'd1);
      endcase
      run_op($sformatf("rand%0d", n), xr, n[0]);
    end

    // Reset mid-operation after a nonzero result is on res
    run_op("x777777", XW'(777777), 0);
    clk_en = 1'b1;
    x = XW'(1000000);
    x_vld = 1'b1;
    @(posedge clk);
    #1;
    x_vld = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst x_rdy", 64'(x_rdy), 64'd1);
    check("midrst res_vld", 64'(res_vld), 64'd0);
    check("midrst res", 64'(res), 64'd0);
`ifdef ROOT_5_EXACT_EN
    check("midrst res_exact", 64'(res_exact), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("x3125 after rst", XW'(3125), 0);

    // Back-to-back with x_vld held high
    ra = ref_root(XW'(59049));
    rb = ref_root(XW'(7777777));
    acc2 = -1;
    vld_cnt = 0;
    clk_en = 1'b1;
    x = XW'(59049);
    x_vld = 1'b1;
    check("b2b idle before", 64'(x_rdy), 64'd1);
    for (int j = 0; j < 105; j++) begin
      pre = x_rdy;
      @(posedge clk);
      #1;
      if (j == 0) x = XW'(7777777);
      if (pre && j > 0 && acc2 < 0) begin
        acc2 = j;
        x_vld = 1'b0;
      end
      if (res_vld) begin
        vld_cnt++;
        check($sformatf("b2b res%0d", vld_cnt), 64'(res), 64'(vld_cnt == 1 ? ra : rb));
      end
    end
    check("b2b second accept", 64'(acc2), 64'(6 * W + 2));
    check("b2b pulse count", 64'(vld_cnt), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
